// File: rtl/pipelined_mac.sv
// rtl/pipelined_mac.sv - pipelined multiply-accumulate with dump strobe, rounding and saturation
module pipelined_mac #(
   parameter int A_WIDTH             = 18,
   parameter int B_WIDTH             = 25,
   parameter int ACC_WIDTH           = 48,
   parameter int OUT_WIDTH           = 32,
   parameter int OUT_SHIFT           = 0,
   parameter int NUM_PIPELINE_LEVELS = 3,
   parameter int SIGNED              = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 valid_in,
   input  logic [A_WIDTH-1:0]   a,
   input  logic [B_WIDTH-1:0]   b,
   input  logic                 acc_en,
   input  logic                 dump,
   output logic [OUT_WIDTH-1:0] p_out,
   output logic                 p_valid,
   output logic                 overflow
);

   localparam int PW    = A_WIDTH + B_WIDTH;
   localparam int RW    = ACC_WIDTH + 1;
   localparam int EXTRA = NUM_PIPELINE_LEVELS - 3;

   if (ACC_WIDTH < PW) begin : g_chk_acc
      $error("pipelined_mac: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
   end
   if (OUT_WIDTH > ACC_WIDTH) begin : g_chk_out
      $error("pipelined_mac: OUT_WIDTH must be <= ACC_WIDTH");
   end
   if (NUM_PIPELINE_LEVELS < 3) begin : g_chk_lvl
      $error("pipelined_mac: NUM_PIPELINE_LEVELS must be >= 3");
   end

   logic [A_WIDTH-1:0]   a_q;
   logic [B_WIDTH-1:0]   b_q;
   logic                 v1_q, en1_q, dump1_q;
   logic [ACC_WIDTH-1:0] prod_ext, prod_q;
   logic                 v2_q, en2_q, dump2_q;

   if (SIGNED != 0) begin : g_mul_s
      logic signed [PW-1:0] prod_s;
      assign prod_s   = PW'($signed(a_q)) * PW'($signed(b_q));
      assign prod_ext = ACC_WIDTH'(prod_s);
   end else begin : g_mul_u
      logic [PW-1:0] prod_u;
      assign prod_u   = PW'(a_q) * PW'(b_q);
      assign prod_ext = ACC_WIDTH'(prod_u);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0; b_q <= '0; v1_q <= 1'b0; en1_q <= 1'b0; dump1_q <= 1'b0;
         prod_q <= '0; v2_q <= 1'b0; en2_q <= 1'b0; dump2_q <= 1'b0;
      end else begin
         a_q     <= a;
         b_q     <= b;
         v1_q    <= valid_in & ~clear;
         en1_q   <= acc_en;
         dump1_q <= dump;
         prod_q  <= prod_ext;
         v2_q    <= v1_q & ~clear;
         en2_q   <= en1_q;
         dump2_q <= dump1_q;
      end
   end

   // product and control as seen by the accumulator after the optional delay line
   logic [ACC_WIDTH-1:0] prod_a;
   logic                 v_a, en_a, dump_a;

   if (EXTRA > 0) begin : g_dly
      logic [ACC_WIDTH-1:0] dprod_q [EXTRA];
      logic [EXTRA-1:0]     dv_q, den_q, ddump_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < EXTRA; i++) dprod_q[i] <= '0;
            dv_q <= '0; den_q <= '0; ddump_q <= '0;
         end else begin
            dprod_q[0] <= prod_q;
            dv_q[0]    <= v2_q & ~clear;
            den_q[0]   <= en2_q;
            ddump_q[0] <= dump2_q;
            for (int i = 1; i < EXTRA; i++) begin
               dprod_q[i] <= dprod_q[i-1];
               dv_q[i]    <= dv_q[i-1] & ~clear;
               den_q[i]   <= den_q[i-1];
               ddump_q[i] <= ddump_q[i-1];
            end
         end
      end
      assign prod_a = dprod_q[EXTRA-1];
      assign v_a    = dv_q[EXTRA-1];
      assign en_a   = den_q[EXTRA-1];
      assign dump_a = ddump_q[EXTRA-1];
   end else begin : g_nodly
      assign prod_a = prod_q;
      assign v_a    = v2_q;
      assign en_a   = en2_q;
      assign dump_a = dump2_q;
   end

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 sticky_q, sticky_d;
   logic                 fire_q;
   logic [ACC_WIDTH:0]   sum_w;
   logic                 add_ovf;

   assign sum_w   = {1'b0, acc_q} + {1'b0, prod_a};
   assign add_ovf = (SIGNED != 0)
                  ? ((acc_q[ACC_WIDTH-1] == prod_a[ACC_WIDTH-1]) && (sum_w[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                  : sum_w[ACC_WIDTH];

   always_comb begin
      acc_d    = acc_q;
      sticky_d = sticky_q;
      if (v_a) begin
         if (en_a) begin
            acc_d    = sum_w[ACC_WIDTH-1:0];
            sticky_d = sticky_q | add_ovf;
         end else begin
            acc_d    = prod_a;
            sticky_d = 1'b0;
         end
      end
   end

   // rounding is done one bit wider than the accumulator so the +half cannot wrap
   logic [RW-1:0] acc_x, r_w;
   assign acc_x = (SIGNED != 0) ? {acc_q[ACC_WIDTH-1], acc_q} : {1'b0, acc_q};

   if (OUT_SHIFT > 0) begin : g_rnd
      logic [RW-1:0] rnd_w;
      assign rnd_w = acc_x + (RW'(1) << (OUT_SHIFT - 1));
      if (SIGNED != 0) begin : g_ars
         assign r_w = RW'($signed(rnd_w) >>> OUT_SHIFT);
      end else begin : g_lrs
         assign r_w = rnd_w >> OUT_SHIFT;
      end
   end else begin : g_nornd
      assign r_w = acc_x;
   end

   logic                 sat_w;
   logic [OUT_WIDTH-1:0] sat_val;

   if (SIGNED != 0) begin : g_sat_s
      assign sat_w   = (r_w[RW-1:OUT_WIDTH-1] != {(RW-OUT_WIDTH+1){r_w[RW-1]}});
      assign sat_val = !sat_w       ? r_w[OUT_WIDTH-1:0]
                     : r_w[RW-1]    ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                    : {1'b0, {(OUT_WIDTH-1){1'b1}}};
   end else begin : g_sat_u
      assign sat_w   = |r_w[RW-1:OUT_WIDTH];
      assign sat_val = sat_w ? {OUT_WIDTH{1'b1}} : r_w[OUT_WIDTH-1:0];
   end

   logic [OUT_WIDTH-1:0] p_out_q;
   logic                 p_valid_q, ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0; sticky_q <= 1'b0; fire_q <= 1'b0;
         p_out_q <= '0; p_valid_q <= 1'b0; ovf_q <= 1'b0;
      end else if (clear) begin
         acc_q     <= '0;
         sticky_q  <= 1'b0;
         fire_q    <= 1'b0;
         p_valid_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         sticky_q  <= sticky_d;
         fire_q    <= v_a & dump_a;
         p_valid_q <= fire_q;
         if (fire_q) begin
            p_out_q <= sat_val;
            ovf_q   <= sat_w | sticky_q;
         end
      end
   end

   assign p_out    = p_out_q;
   assign p_valid  = p_valid_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_pipelined_mac.sv
// tb/tb_pipelined_mac.sv - self-checking bench for pipelined_mac over five parameter sets
module tb_pipelined_mac;

   localparam int CYC = 2048;
   localparam int NI  = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clear = 1'b0, valid_in = 1'b0, acc_en = 1'b0, dump = 1'b0;
   logic [17:0] a = '0;
   logic [24:0] b = '0;

   logic [31:0] po0, po1, po2, po4;
   logic [42:0] po3;
   logic        pv0, pv1, pv2, pv3, pv4;
   logic        ov0, ov1, ov2, ov3, ov4;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   // instance configuration: signed, acc width, out width, shift, pipeline levels
   int c_sg [NI] = '{1, 0, 1, 1, 1};
   int c_aw [NI] = '{48, 48, 48, 43, 48};
   int c_ow [NI] = '{32, 32, 32, 43, 32};
   int c_sh [NI] = '{0, 0, 4, 0, 0};
   int c_n  [NI] = '{3, 3, 3, 3, 5};

   longint      m_acc    [NI];
   bit          m_sticky [NI];
   bit          exp_v [NI][CYC];
   logic [63:0] exp_p [NI][CYC];
   bit          exp_o [NI][CYC];
   logic        obs_v [NI][CYC];
   logic [63:0] obs_p [NI][CYC];
   logic        obs_o [NI][CYC];

   pipelined_mac u0 (.clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .a(a), .b(b),
                     .acc_en(acc_en), .dump(dump), .p_out(po0), .p_valid(pv0), .overflow(ov0));
   pipelined_mac #(.SIGNED(0)) u1 (.clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .a(a), .b(b),
                     .acc_en(acc_en), .dump(dump), .p_out(po1), .p_valid(pv1), .overflow(ov1));
   pipelined_mac #(.OUT_SHIFT(4)) u2 (.clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .a(a), .b(b),
                     .acc_en(acc_en), .dump(dump), .p_out(po2), .p_valid(pv2), .overflow(ov2));
   pipelined_mac #(.A_WIDTH(18), .B_WIDTH(25), .ACC_WIDTH(43), .OUT_WIDTH(43)) u3 (.clk(clk), .rst_n(rst_n),
                     .clear(clear), .valid_in(valid_in), .a(a), .b(b),
                     .acc_en(acc_en), .dump(dump), .p_out(po3), .p_valid(pv3), .overflow(ov3));
   pipelined_mac #(.NUM_PIPELINE_LEVELS(5)) u4 (.clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .a(a), .b(b),
                     .acc_en(acc_en), .dump(dump), .p_out(po4), .p_valid(pv4), .overflow(ov4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < CYC) begin
         obs_v[0][cyc] = pv0; obs_p[0][cyc] = 64'(po0); obs_o[0][cyc] = ov0;
         obs_v[1][cyc] = pv1; obs_p[1][cyc] = 64'(po1); obs_o[1][cyc] = ov1;
         obs_v[2][cyc] = pv2; obs_p[2][cyc] = 64'(po2); obs_o[2][cyc] = ov2;
         obs_v[3][cyc] = pv3; obs_p[3][cyc] = 64'(po3); obs_o[3][cyc] = ov3;
         obs_v[4][cyc] = pv4; obs_p[4][cyc] = 64'(po4); obs_o[4][cyc] = ov4;
      end
   end

   // Reference: exact integer arithmetic, range checks for overflow, floor division for rounding.
   task automatic model_sample(input int i, input logic [17:0] av, input logic [24:0] bv,
                               input bit en, input bit dmp, input int c);
      longint one, pa, pb, sum, lo, hi, r, rlo, rhi;
      bit ovf, sat;
      one = 1;
      if (c_sg[i] != 0) begin
         pa = longint'($signed(av)); pb = longint'($signed(bv));
         lo = -(one << (c_aw[i]-1)); hi = (one << (c_aw[i]-1)) - 1;
         rlo = -(one << (c_ow[i]-1)); rhi = (one << (c_ow[i]-1)) - 1;
      end else begin
         pa = longint'(av); pb = longint'(bv);
         lo = 0; hi = (one << c_aw[i]) - 1;
         rlo = 0; rhi = (one << c_ow[i]) - 1;
      end
      sum = en ? m_acc[i] + pa * pb : pa * pb;
      ovf = (sum < lo) || (sum > hi);
      if (sum > hi) sum = sum - (one << c_aw[i]);
      else if (sum < lo) sum = sum + (one << c_aw[i]);
      m_acc[i]    = sum;
      m_sticky[i] = en ? (m_sticky[i] | ovf) : 1'b0;
      if (dmp && (c + c_n[i] + 1 < CYC)) begin
         r = (c_sh[i] > 0) ? (sum + (one << (c_sh[i]-1))) >>> c_sh[i] : sum;
         sat = (r < rlo) || (r > rhi);
         if (r < rlo) r = rlo;
         if (r > rhi) r = rhi;
         exp_v[i][c + c_n[i] + 1] = 1'b1;
         exp_p[i][c + c_n[i] + 1] = 64'(r & ((one << c_ow[i]) - 1));
         exp_o[i][c + c_n[i] + 1] = sat | m_sticky[i];
      end
   endtask

   task automatic model_flush(input int from_c);
      for (int i = 0; i < NI; i++) begin
         m_acc[i] = 0; m_sticky[i] = 1'b0;
         for (int d = from_c; d < from_c + 10; d++) if (d < CYC) exp_v[i][d] = 1'b0;
      end
   endtask

   task automatic drive(input bit v, input logic [17:0] av, input logic [24:0] bv,
                        input bit en, input bit dmp, input bit clr);
      @(posedge clk); #1;
      valid_in = v; a = av; b = bv; acc_en = en; dump = dmp; clear = clr;
      if (clr) model_flush(cyc + 1);
      else if (v) for (int i = 0; i < NI; i++) model_sample(i, av, bv, en, dmp, cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if ({pv0, pv1, pv2, pv3, pv4, ov0, ov1, ov2, ov3, ov4} !== 10'b0 || {po0, po1, po2, po4} !== 128'b0 || po3 !== 43'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got pv=%b%b%b%b%b p_out0=%h want all 0", pv0, pv1, pv2, pv3, pv4, po0);
      end
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < NI; i++) begin m_acc[i] = 0; m_sticky[i] = 1'b0; end
   endtask

   task automatic test_latency;
      int t;
      t = cyc + 1;
      drive(1'b1, -18'sd3, 25'sd7, 1'b0, 1'b1, 1'b0);
      idle(9);
      vectors += 4;
      if (obs_v[0][t+3] !== 1'b0 || obs_v[0][t+4] !== 1'b1 || obs_v[0][t+5] !== 1'b0) begin
         miscompares++;
         $display("FAIL lat3_valid: got %b%b%b want 010 at cycles +3..+5", obs_v[0][t+3], obs_v[0][t+4], obs_v[0][t+5]);
      end
      if (obs_p[0][t+4] !== 64'hFFFF_FFEB || obs_o[0][t+4] !== 1'b0) begin
         miscompares++;
         $display("FAIL lat3_value: got %h ovf %b want ffffffeb ovf 0", obs_p[0][t+4], obs_o[0][t+4]);
      end
      if (obs_v[4][t+5] !== 1'b0 || obs_v[4][t+6] !== 1'b1 || obs_v[4][t+7] !== 1'b0) begin
         miscompares++;
         $display("FAIL lat5_valid: got %b%b%b want 010 at cycles +5..+7", obs_v[4][t+5], obs_v[4][t+6], obs_v[4][t+7]);
      end
      if (obs_p[4][t+6] !== 64'hFFFF_FFEB) begin
         miscompares++;
         $display("FAIL lat5_value: got %h want ffffffeb", obs_p[4][t+6]);
      end
   endtask

   task automatic test_accumulate;
      int t;
      t = cyc + 1;
      drive(1'b1, 18'd1000, 25'd1000, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 18'd1000, 25'd1000, 1'b1, 1'b0, 1'b0);
      idle(1);
      drive(1'b1, 18'd1000, 25'd1000, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 18'd1000, 25'd1000, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 18'd2, 25'd5, 1'b1, 1'b1, 1'b0);
      idle(8);
      vectors += 3;
      if ({obs_v[0][t+4], obs_v[0][t+5], obs_v[0][t+6], obs_v[0][t+7]} !== 4'b0) begin
         miscompares++;
         $display("FAIL acc_early_valid: got %b%b%b%b want 0000", obs_v[0][t+4], obs_v[0][t+5], obs_v[0][t+6], obs_v[0][t+7]);
      end
      if (obs_v[0][t+8] !== 1'b1 || obs_p[0][t+8] !== 64'd4000000) begin
         miscompares++;
         $display("FAIL acc_sum4: got v=%b %0d want v=1 4000000", obs_v[0][t+8], obs_p[0][t+8]);
      end
      if (obs_v[0][t+9] !== 1'b1 || obs_p[0][t+9] !== 64'd4000010 || obs_o[0][t+9] !== 1'b0) begin
         miscompares++;
         $display("FAIL acc_sum5: got v=%b %0d ovf %b want v=1 4000010 ovf 0", obs_v[0][t+9], obs_p[0][t+9], obs_o[0][t+9]);
      end
   endtask

   task automatic test_saturation;
      int t;
      t = cyc + 1;
      drive(1'b1, 18'd131071, 25'd16777215, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 18'h20000, 25'd16777215, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 18'd3, 25'd5, 1'b0, 1'b1, 1'b0);
      idle(8);
      vectors += 3;
      if (obs_p[0][t+4] !== 64'h7FFF_FFFF || obs_o[0][t+4] !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_pos: got %h ovf %b want 7fffffff ovf 1", obs_p[0][t+4], obs_o[0][t+4]);
      end
      if (obs_p[0][t+5] !== 64'h8000_0000 || obs_o[0][t+5] !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_neg: got %h ovf %b want 80000000 ovf 1", obs_p[0][t+5], obs_o[0][t+5]);
      end
      if (obs_v[1][t+6] !== 1'b1 || obs_p[1][t+6] !== 64'd15 || obs_o[1][t+6] !== 1'b0) begin
         miscompares++;
         $display("FAIL unsigned_small: got v=%b %0d ovf %b want v=1 15 ovf 0", obs_v[1][t+6], obs_p[1][t+6], obs_o[1][t+6]);
      end
   endtask

   task automatic test_rounding;
      int t;
      t = cyc + 1;
      drive(1'b1, 18'd25, 25'd1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, -18'sd24, 25'd1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 18'd23, 25'd1, 1'b0, 1'b1, 1'b0);
      idle(8);
      vectors += 3;
      if (obs_p[2][t+4] !== 64'd2) begin
         miscompares++; $display("FAIL round_25: got %h want 2", obs_p[2][t+4]);
      end
      if (obs_p[2][t+5] !== 64'hFFFF_FFFF) begin
         miscompares++; $display("FAIL round_m24: got %h want ffffffff", obs_p[2][t+5]);
      end
      if (obs_p[2][t+6] !== 64'd1 || obs_o[2][t+6] !== 1'b0) begin
         miscompares++; $display("FAIL round_23: got %h ovf %b want 1 ovf 0", obs_p[2][t+6], obs_o[2][t+6]);
      end
   endtask

   task automatic test_wrap;
      int t;
      t = cyc + 1;
      drive(1'b1, 18'h20000, 25'h1000000, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 18'h20000, 25'h1000000, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 18'd1, 25'd1, 1'b0, 1'b1, 1'b0);
      idle(8);
      vectors += 2;
      if (obs_v[3][t+5] !== 1'b1 || obs_p[3][t+5] !== 64'h0000_0400_0000_0000 || obs_o[3][t+5] !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_flag: got v=%b %h ovf %b want v=1 40000000000 ovf 1", obs_v[3][t+5], obs_p[3][t+5], obs_o[3][t+5]);
      end
      if (obs_p[3][t+6] !== 64'd1 || obs_o[3][t+6] !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_reload: got %h ovf %b want 1 ovf 0", obs_p[3][t+6], obs_o[3][t+6]);
      end
   endtask

   task automatic test_clear;
      int t;
      t = cyc + 1;
      drive(1'b1, 18'd5, 25'd5, 1'b0, 1'b1, 1'b0);
      idle(1);
      drive(1'b1, 18'd9, 25'd9, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 18'd4, 25'd4, 1'b1, 1'b1, 1'b0);
      idle(9);
      vectors += 4;
      if ({obs_v[0][t+3], obs_v[0][t+4], obs_v[0][t+5], obs_v[0][t+6], obs_v[4][t+5], obs_v[4][t+6], obs_v[4][t+7], obs_v[4][t+8]} !== 8'b0) begin
         miscompares++;
         $display("FAIL clear_drop: got u0 %b%b%b%b u4 %b%b%b%b want all 0", obs_v[0][t+3], obs_v[0][t+4], obs_v[0][t+5],
                  obs_v[0][t+6], obs_v[4][t+5], obs_v[4][t+6], obs_v[4][t+7], obs_v[4][t+8]);
      end
      if (obs_p[0][t+6] !== 64'd1) begin
         miscompares++; $display("FAIL clear_hold: got %h want 1", obs_p[0][t+6]);
      end
      if (obs_v[0][t+7] !== 1'b1 || obs_p[0][t+7] !== 64'd16) begin
         miscompares++; $display("FAIL clear_restart: got v=%b %0d want v=1 16", obs_v[0][t+7], obs_p[0][t+7]);
      end
      if (obs_v[4][t+9] !== 1'b1 || obs_p[4][t+9] !== 64'd16) begin
         miscompares++; $display("FAIL clear_restart5: got v=%b %0d want v=1 16", obs_v[4][t+9], obs_p[4][t+9]);
      end
   endtask

   task automatic test_async_reset;
      int t, rc;
      t = cyc + 1;
      for (int k = 0; k < 6; k++) drive(1'b1, 18'(k + 1), 25'd3, 1'b0, 1'b1, 1'b0);
      rc = cyc;
      #2 rst_n = 1'b0;
      #1;
      model_flush(rc);
      vectors++;
      if ({pv0, pv1, pv2, pv3, pv4} !== 5'b0 || {po0, po1, po2, po4} !== 128'b0 || po3 !== 43'b0) begin
         miscompares++;
         $display("FAIL async_reset: got pv=%b%b%b%b%b p_out0=%h want all 0", pv0, pv1, pv2, pv3, pv4, po0);
      end
      idle(2);
      #1 rst_n = 1'b1;
      idle(8);
      for (int c = rc; c < rc + 9; c++) begin
         vectors++;
         if (obs_v[0][c] !== 1'b0 || obs_v[4][c] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_stale: cycle %0d got u0=%b u4=%b want 0", c - t, obs_v[0][c], obs_v[4][c]);
         end
      end
   endtask

   task automatic test_random_scoreboard;
      logic [17:0] av;
      logic [24:0] bv;
      int cend;
      for (int k = 0; k < 700; k++) begin
         case ($urandom_range(0, 5))
            0: av = 18'h1FFFF;
            1: av = 18'h20000;
            default: av = 18'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0: bv = 25'hFFFFFF;
            1: bv = 25'h1000000;
            default: bv = 25'($urandom);
         endcase
         drive($urandom_range(0, 4) != 0, av, bv, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
      end
      idle(10);
      cend = cyc;
      for (int c = 1; c < cend; c++) begin
         for (int i = 0; i < NI; i++) begin
            vectors++;
            if (obs_v[i][c] !== exp_v[i][c]) begin
               miscompares++;
               $display("FAIL sb_valid u%0d cycle %0d: got %b want %b", i, c, obs_v[i][c], exp_v[i][c]);
            end else if (exp_v[i][c] && (obs_p[i][c] !== exp_p[i][c] || obs_o[i][c] !== exp_o[i][c])) begin
               miscompares++;
               $display("FAIL sb_value u%0d cycle %0d: got %h ovf %b want %h ovf %b", i, c,
                        obs_p[i][c], obs_o[i][c], exp_p[i][c], exp_o[i][c]);
            end
         end
      end
   endtask

   initial begin
      test_reset;
      idle(2);
      test_latency;
      test_accumulate;
      test_saturation;
      test_rounding;
      test_wrap;
      test_clear;
      test_async_reset;
      test_random_scoreboard;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipelined_mac.md
Name: pipelined_mac

Overview:
- Parametrised successor to the plain pipelined multiplier: a signed/unsigned multiply-accumulate block with valid qualification, accumulate/load control and dump strobes.
- Output is rounded, shifted and saturated to a narrower width.
- Used for dot products, integrate-and-dump filters and gain stages in the DSP datapath.
- Infers one DSP48-class slice for default widths.

Parameters:
- A_WIDTH, 18, width of operand a.
- B_WIDTH, 25, width of operand b.
- ACC_WIDTH, 48, accumulator width; must be >= A_WIDTH+B_WIDTH (elaboration error otherwise).
- OUT_WIDTH, 32, output width; must be <= ACC_WIDTH.
- OUT_SHIFT, 0, right shift applied to the accumulator before saturation.
- NUM_PIPELINE_LEVELS, 3, input-to-accumulator stages; minimum 3 (elaboration error otherwise).
- SIGNED, 1, 1 = two's-complement operands and result; 0 = unsigned.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush: zero accumulator, drop in-flight samples
- valid_in  in  1  a, b, acc_en, dump are valid this cycle
- a  in  A_WIDTH  operand a
- b  in  B_WIDTH  operand b
- acc_en  in  1  1 = add product to accumulator; 0 = load product (start new sum)
- dump  in  1  this sample closes the sum; emit result
- p_out  out  OUT_WIDTH  rounded, shifted, saturated result
- p_valid  out  1  one-cycle strobe, p_out valid
- overflow  out  1  qualified by p_valid: accumulator wrapped or output saturated

Behaviour:
- Reset: rst_n low asynchronously zeroes every register, including pipeline valids, accumulator, sticky flag, p_out, p_valid and overflow. Outputs read 0 while reset is held.
- Stage 1 registers a, b, valid_in, acc_en and dump.
- Stage 2 registers the full product. The product is sign-extended (SIGNED=1) or zero-extended to ACC_WIDTH.
- NUM_PIPELINE_LEVELS-3 extra delay registers follow on product and control.
- Final stage is the accumulator. It updates only when the delayed valid is 1:
  - acc_en=1: acc <= acc + prod (wraps modulo 2^ACC_WIDTH).
  - acc_en=0: acc <= prod.
  - When the delayed valid is 0, acc holds.
- Accumulator overflow:
  - SIGNED=1: overflow when the operand signs match and the result sign differs.
  - SIGNED=0: overflow on carry out.
  - Any overflow sets a sticky flag; a load (acc_en=0) resets it to that sample's overflow, i.e. 0.
- Output register: loads one cycle after an accumulator update whose delayed dump=1.
  - OUT_SHIFT>0: r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (arithmetic shift when SIGNED=1, logical otherwise). Round-half-up is evaluated at ACC_WIDTH+1 bits, so no internal wrap.
  - OUT_SHIFT=0: r = acc.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] when SIGNED=1, or [0, 2^OUT_WIDTH-1] when SIGNED=0.
  - overflow = saturation occurred OR sticky flag.
  - p_valid pulses for one cycle; p_out holds its last value until the next dump.
- Latency: sample with dump=1 presented at cycle 0 gives p_valid=1 at cycle NUM_PIPELINE_LEVELS+1.
- Throughput: one sample per cycle. Back-to-back dumps are legal; each gives a p_valid.
- dump and acc_en are ignored when valid_in=0. dump=1 with acc_en=0 emits a single product.
- Gaps in valid_in do not disturb the accumulator.
- clear (synchronous, higher priority than everything):
  - Zeroes all pipeline valids, the accumulator and the sticky flag.
  - The next cycle p_valid=0; p_out keeps its old value.
  - A sample on the same cycle as clear is discarded.
  - A later sample with acc_en=1 adds onto 0.
- No backpressure; the consumer must accept p_valid.

Test Plan:
- Defaults (latency 4): a=-3, b=7, valid_in=1, acc_en=0, dump=1 at cycle 0 -> cycle 4: p_valid=1, p_out=0xFFFFFFEB (-21), overflow=0; p_valid=0 at cycle 5.
- Accumulate: four consecutive samples a=1000, b=1000, acc_en=0,1,1,1, dump only on the 4th, one idle cycle inserted between 2nd and 3rd -> single p_valid with p_out=4000000. Immediately following sample a=2, b=5, acc_en=1, dump=1 -> p_out=4000010.
- Saturation:
  - a=131071, b=16777215, dump=1 -> p_out=0x7FFFFFFF, overflow=1.
  - a=-131072, b=16777215 -> p_out=0x80000000, overflow=1.
  - SIGNED=0, a=3, b=5 -> p_out=15, overflow=0.
- Rounding, OUT_SHIFT=4:
  - a=25, b=1 -> p_out=2.
  - a=-24, b=1 -> p_out=-1 (0xFFFFFFFF).
  - a=23, b=1 -> p_out=1.
- Accumulator wrap, ACC_WIDTH=43, OUT_WIDTH=43, A=18, B=25: repeated max-positive products with acc_en=1 until the sign flips, dump -> overflow=1. Next load sample with dump -> overflow=0.
- Clear and reset:
  - clear asserted 2 cycles after a dump sample -> no p_valid.
  - Then a=4, b=4, acc_en=1, dump=1 -> p_out=16.
  - rst_n pulsed low mid-stream, asynchronous to clk -> p_out=0, p_valid=0 immediately, no output from pre-reset samples.
  - Repeat the latency check with NUM_PIPELINE_LEVELS=5 -> p_valid at cycle 6.
